// File: rtl/btb_update_unit_if.sv
// Resolution-side and BTB-write-side signal bundle for the BTB update unit.
// The master modport is the pipeline/BTB side that supplies resolutions and
// accepts writes. The slave modport is the update unit itself.
interface btb_update_unit_if;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_pc;
  logic        res_uc;
  logic        res_taken;
  logic [15:0] res_target;
  logic [15:0] res_next_pc;
  logic        res_pred_hit;
  logic [15:0] res_pred_target;
  logic        btb_write;
  logic        btb_wr_ready;
  logic [3:0]  btb_index;
  logic [11:0] btb_tag;
  logic [15:0] btb_target;
  logic        btb_uc;

  modport master (
    output res_valid, res_pc, res_uc, res_taken, res_target, res_next_pc,
           res_pred_hit, res_pred_target, btb_wr_ready,
    input  res_ready, btb_write, btb_index, btb_tag, btb_target, btb_uc
  );

  modport slave (
    input  res_valid, res_pc, res_uc, res_taken, res_target, res_next_pc,
           res_pred_hit, res_pred_target, btb_wr_ready,
    output res_ready, btb_write, btb_index, btb_tag, btb_target, btb_uc
  );
endinterface

// File: rtl/btb_update_unit.sv
// MEM-stage branch resolution: mispredict detection, registered fetch
// redirect, 2-entry coalescing BTB allocation queue, saturating counters.
module btb_update_unit #(
  parameter int CNT_W  = 16,
  parameter int QDEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  btb_update_unit_if.slave   bus,
  output logic               redirect,
  output logic [15:0]        redirect_pc,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   cnt_resolved,
  output logic [CNT_W-1:0]   cnt_mispred
);
  localparam logic [1:0] FULL = 2'(QDEPTH);

  typedef struct packed {
    logic [3:0]  index;
    logic [11:0] tag;
    logic [15:0] target;
    logic        uc;
  } entry_t;

  // slot0 is always the queue head; slot1 is the younger entry
  entry_t           slot0_r, slot1_r;
  logic [1:0]       count_r;
  logic             redirect_r;
  logic [15:0]      redirect_pc_r;
  logic [CNT_W-1:0] cnt_resolved_r, cnt_mispred_r;

  entry_t     new_s, e0_upd_s, e1_upd_s, slot0_n_s, slot1_n_s;
  logic [1:0] count_tmp_s, count_n_s;
  logic       accept_s, mispred_s, alloc_s, deq_s;
  logic       match0_s, match1_s, coal_s, enq_s;

  // res_ready comes from the registered occupancy only, never from a same-cycle dequeue
  assign bus.res_ready  = (count_r != FULL);
  assign bus.btb_write  = (count_r != 2'd0);
  assign bus.btb_index  = slot0_r.index;
  assign bus.btb_tag    = slot0_r.tag;
  assign bus.btb_target = slot0_r.target;
  assign bus.btb_uc     = slot0_r.uc;
  assign redirect       = redirect_r;
  assign redirect_pc    = redirect_pc_r;
  assign cnt_resolved   = cnt_resolved_r;
  assign cnt_mispred    = cnt_mispred_r;

  // Resolution decode: accept, mispredict and allocation decisions
  always_comb begin
    accept_s  = bus.res_valid && (count_r != FULL);
    mispred_s = (bus.res_taken != bus.res_pred_hit) ||
                (bus.res_taken && bus.res_pred_hit &&
                 (bus.res_target != bus.res_pred_target));
    // Not-taken never allocates: the BTB has no invalidate path
    alloc_s   = accept_s && bus.res_taken &&
                (!bus.res_pred_hit || (bus.res_target != bus.res_pred_target));
    new_s     = '{index: bus.res_pc[3:0], tag: bus.res_pc[15:4],
                  target: bus.res_target, uc: bus.res_uc};
  end

  // Queue next-state: coalesce into a live entry, then dequeue, then enqueue
  always_comb begin
    deq_s    = (count_r != 2'd0) && bus.btb_wr_ready;
    match0_s = (count_r != 2'd0) && !deq_s &&
               ({slot0_r.index, slot0_r.tag} == {new_s.index, new_s.tag});
    match1_s = (count_r == 2'd2) &&
               ({slot1_r.index, slot1_r.tag} == {new_s.index, new_s.tag});
    coal_s   = alloc_s && (match0_s || match1_s);
    enq_s    = alloc_s && !coal_s;
    e0_upd_s = slot0_r;
    e1_upd_s = slot1_r;
    // When both entries match, the younger one (slot1) takes the update
    if (coal_s && match1_s) begin
      e1_upd_s.target = new_s.target;
      e1_upd_s.uc     = new_s.uc;
    end else if (coal_s) begin
      e0_upd_s.target = new_s.target;
      e0_upd_s.uc     = new_s.uc;
    end else begin
      e0_upd_s = slot0_r;
    end
    if (deq_s) begin
      slot0_n_s   = e1_upd_s;
      slot1_n_s   = e1_upd_s;
      count_tmp_s = count_r - 2'd1;
    end else begin
      slot0_n_s   = e0_upd_s;
      slot1_n_s   = e1_upd_s;
      count_tmp_s = count_r;
    end
    // Enqueue only happens on accept, so count_tmp_s is at most 1 here
    if (enq_s && (count_tmp_s == 2'd0)) begin
      slot0_n_s = new_s;
      count_n_s = 2'd1;
    end else if (enq_s) begin
      slot1_n_s = new_s;
      count_n_s = count_tmp_s + 2'd1;
    end else begin
      count_n_s = count_tmp_s;
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      slot0_r <= slot0_n_s;
      slot1_r <= slot1_n_s;
      count_r <= count_n_s;
    end
  end

  // One-cycle redirect pulse; the PC holds its last value between pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_r    <= 1'b0;
      redirect_pc_r <= 16'h0000;
    end else begin
      redirect_r <= accept_s && mispred_s;
      if (accept_s && mispred_s) begin
        redirect_pc_r <= bus.res_taken ? bus.res_target : bus.res_next_pc;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_resolved_r <= '0;
      cnt_mispred_r  <= '0;
    end else if (cnt_clear) begin
      cnt_resolved_r <= '0;
      cnt_mispred_r  <= '0;
    end else begin
      if (accept_s && !(&cnt_resolved_r)) begin
        cnt_resolved_r <= cnt_resolved_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_resolved_r <= cnt_resolved_r;
      end
      if (accept_s && mispred_s && !(&cnt_mispred_r)) begin
        cnt_mispred_r <= cnt_mispred_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_mispred_r <= cnt_mispred_r;
      end
    end
  end
endmodule
